// File: rtl/td4_pkg.sv
// Shared TD4 decode constants: opcodes, ALU source selects and load-enable bit positions.
package td4_pkg;

   typedef enum logic [3:0] {
      OP_ADD_A  = 4'b0000,
      OP_MOV_AB = 4'b0001,
      OP_IN_A   = 4'b0010,
      OP_MOV_A  = 4'b0011,
      OP_MOV_BA = 4'b0100,
      OP_ADD_B  = 4'b0101,
      OP_IN_B   = 4'b0110,
      OP_MOV_B  = 4'b0111,
      OP_OUT_B  = 4'b1001,
      OP_OUT_IM = 4'b1011,
      OP_JNC    = 4'b1110,
      OP_JMP    = 4'b1111
   } op_e;

   typedef enum logic [1:0] {
      SRC_A    = 2'b00,
      SRC_B    = 2'b01,
      SRC_IN   = 2'b10,
      SRC_ZERO = 2'b11
   } src_e;

   localparam int LD_A   = 0;
   localparam int LD_B   = 1;
   localparam int LD_OUT = 2;
   localparam int LD_PC  = 3;

   // Opcodes 1000, 1010, 1100 and 1101 have no TD4 instruction behind them.
   function automatic logic op_is_legal(input logic [3:0] op);
      logic legal;
      case (op)
         4'b1000, 4'b1010, 4'b1100, 4'b1101: legal = 1'b0;
         default:                            legal = 1'b1;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/td4_op_decoder.sv
// TD4 instruction decoder: combinational source select and one-hot load enables,
// plus a sticky flag recording any undefined opcode seen at a clock edge.
module td4_op_decoder
   import td4_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] op,
   input  logic       c_flg,
   output logic       select_a,
   output logic       select_b,
   output logic [3:0] load,
   output logic       illegal_op
);

   src_e       src_s;
   logic [3:0] load_s;
   logic       illegal_op_d;
   logic       illegal_op_q;

   // Opcode decode; undefined opcodes fall through to a NOP with the zero source.
   always_comb begin
      src_s  = SRC_ZERO;
      load_s = 4'b0000;
      case (op)
         OP_ADD_A:  begin src_s = SRC_A;    load_s[LD_A]   = 1'b1; end
         OP_MOV_AB: begin src_s = SRC_B;    load_s[LD_A]   = 1'b1; end
         OP_IN_A:   begin src_s = SRC_IN;   load_s[LD_A]   = 1'b1; end
         OP_MOV_A:  begin src_s = SRC_ZERO; load_s[LD_A]   = 1'b1; end
         OP_MOV_BA: begin src_s = SRC_A;    load_s[LD_B]   = 1'b1; end
         OP_ADD_B:  begin src_s = SRC_B;    load_s[LD_B]   = 1'b1; end
         OP_IN_B:   begin src_s = SRC_IN;   load_s[LD_B]   = 1'b1; end
         OP_MOV_B:  begin src_s = SRC_ZERO; load_s[LD_B]   = 1'b1; end
         OP_OUT_B:  begin src_s = SRC_B;    load_s[LD_OUT] = 1'b1; end
         OP_OUT_IM: begin src_s = SRC_ZERO; load_s[LD_OUT] = 1'b1; end
         OP_JNC: begin
            src_s = SRC_ZERO;
            if (c_flg == 1'b0) begin
               load_s[LD_PC] = 1'b1;
            end else begin
               load_s[LD_PC] = 1'b0;
            end
         end
         OP_JMP:    begin src_s = SRC_ZERO; load_s[LD_PC]  = 1'b1; end
         default:   begin src_s = SRC_ZERO; load_s         = 4'b0000; end
      endcase
   end

   // Next value of the sticky illegal flag.
   always_comb begin
      illegal_op_d = illegal_op_q | ~op_is_legal(op);
   end

   // Sticky illegal flag; synchronous reset wins over a coincident undefined opcode.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_op_q <= 1'b0;
      end else begin
         illegal_op_q <= illegal_op_d;
      end
   end

   assign select_a   = src_s[0];
   assign select_b   = src_s[1];
   assign load       = load_s;
   assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_td4_op_decoder.sv
// Self-checking bench for td4_op_decoder: table-driven reference model, exhaustive
// sweep, directed literal checks and randomized stimulus with random resets.
module tb_td4_op_decoder;

   logic       clk;
   logic       reset;
   logic [3:0] op;
   logic       c_flg;
   logic       select_a;
   logic       select_b;
   logic [3:0] load;
   logic       illegal_op;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference tables: source code and destination (0=A 1=B 2=OUT 3=PC 4=none).
   int src_tab [16];
   int dst_tab [16];
   bit undef_tab [16];

   bit m_ill   = 1'b0;
   bit m_valid = 1'b0;
   bit chk_en  = 1'b0;

   td4_op_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .c_flg     (c_flg),
      .select_a  (select_a),
      .select_b  (select_b),
      .load      (load),
      .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: op=%b c=%b got %h expected %h", name, op, c_flg, act, exp);
      end
   endtask

   function automatic logic [5:0] model_out(input logic [3:0] o, input logic c);
      int d;
      logic [3:0] ld;
      d = dst_tab[o];
      if (o == 4'b1110 && c == 1'b1) d = 4;
      ld = (d < 4) ? (4'b0001 << d) : 4'b0000;
      return {src_tab[o][1:0], ld};
   endfunction

   // Sticky-flag model: follows the inputs present at each rising edge.
   always @(posedge clk) begin
      if (reset === 1'b1) begin
         m_ill   = 1'b0;
         m_valid = 1'b1;
      end else if (undef_tab[op]) begin
         m_ill = 1'b1;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("decode", {2'b00, select_b, select_a, load}, {2'b00, model_out(op, c_flg)});
         n_cmp++;
         if ($isunknown({select_b, select_a, load, illegal_op}) || !$onehot0(load)) begin
            n_bad++;
            $display("FAIL sanity: got load=%b sel=%b%b ill=%b required known and onehot0",
                     load, select_b, select_a, illegal_op);
         end
         if (m_valid) chk("illegal", {7'd0, illegal_op}, {7'd0, m_ill});
      end
   end

   task automatic apply(input logic [3:0] o, input logic c, input logic r);
      @(posedge clk);
      #1;
      op    = o;
      c_flg = c;
      reset = r;
   endtask

   task automatic lit(input string name, input logic [5:0] exp_out, input logic exp_ill);
      @(negedge clk);
      #1;
      chk({name, "_out"}, {2'b00, select_b, select_a, load}, {2'b00, exp_out});
      chk({name, "_ill"}, {7'd0, illegal_op}, {7'd0, exp_ill});
   endtask

   initial begin
      int srcs [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 3, 1, 3, 3, 3, 3, 3, 3};
      int dsts [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 4, 2, 4, 2, 4, 4, 3, 3};
      for (int i = 0; i < 16; i++) begin
         src_tab[i]   = srcs[i];
         dst_tab[i]   = dsts[i];
         undef_tab[i] = (i == 8) || (i == 10) || (i == 12) || (i == 13);
      end
      reset = 1'b1;
      op    = 4'b0000;
      c_flg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      lit("reset_state", 6'b00_0001, 1'b0);

      // Exhaustive sweep of all opcode/carry combinations.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         v = 5'(i);
         apply(v[4:1], v[0], 1'b0);
      end
      apply(4'b0011, 1'b0, 1'b1);

      // Hand-computed expectations pinning the model.
      apply(4'b1110, 1'b0, 1'b0); lit("jnc_c0", 6'b11_1000, 1'b0);
      apply(4'b1110, 1'b1, 1'b0); lit("jnc_c1", 6'b11_0000, 1'b0);
      apply(4'b1111, 1'b0, 1'b0); lit("jmp_c0", 6'b11_1000, 1'b0);
      apply(4'b1111, 1'b1, 1'b0); lit("jmp_c1", 6'b11_1000, 1'b0);
      apply(4'b0000, 1'b1, 1'b0); lit("add_a_c1", 6'b00_0001, 1'b0);
      apply(4'b1001, 1'b1, 1'b0); lit("out_b", 6'b01_0100, 1'b0);
      apply(4'b0110, 1'b0, 1'b0); lit("in_b", 6'b10_0010, 1'b0);
      apply(4'b1010, 1'b0, 1'b0); lit("undef_now", 6'b11_0000, 1'b0);
      apply(4'b0011, 1'b0, 1'b0); lit("undef_set", 6'b11_0001, 1'b1);
      apply(4'b0011, 1'b0, 1'b0); lit("undef_hold", 6'b11_0001, 1'b1);
      apply(4'b1100, 1'b0, 1'b1); lit("rst_pending", 6'b11_0000, 1'b1);
      apply(4'b0011, 1'b0, 1'b0); lit("rst_wins", 6'b11_0001, 1'b0);

      // Randomized stimulus with occasional resets.
      for (int i = 0; i < 400; i++) begin
         apply(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
               ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
